// File: rtl/max_ctrl.sv
// Capture-window controller: runs the max datapath for win_len cycles, captures its maxima,
// enforces a cool-down, then holds the result until accepted. MAX_CTRL_TMO_EN adds a WAIT timeout.
`timescale 1ns/1ps
module max_ctrl #(
    parameter  int unsigned COOL_CYC = 4,
    parameter  int unsigned TMO_CYC  = 15,
    localparam int unsigned DW       = 12,
    localparam int unsigned LW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] win_len,
    output logic          busy,
    output logic          max_en,
    input  logic          max_done,
    input  logic [DW-1:0] max_out_1,
    input  logic [DW-1:0] max_out_2,
    input  logic [DW-1:0] max_out_3,
    input  logic [DW-1:0] max_out_4,
    output logic [DW-1:0] res_1,
    output logic [DW-1:0] res_2,
    output logic [DW-1:0] res_3,
    output logic [DW-1:0] res_4,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          err
);

    localparam int unsigned COOL_LOAD = (COOL_CYC == 0) ? 1 : COOL_CYC;
    localparam int unsigned COOL_W    = $clog2(COOL_LOAD + 1);
    localparam int unsigned TMO_W     = $clog2(TMO_CYC + 2);
    localparam int unsigned CNT_W0    = (COOL_W > LW) ? COOL_W : LW;
    localparam int unsigned CNT_W     = (TMO_W > CNT_W0) ? TMO_W : CNT_W0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_COOL = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    // One counter serves RUN (window down-count), WAIT (timeout up-count) and COOL (down-count).
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             capture;

`ifdef MAX_CTRL_TMO_EN
    localparam int unsigned TMO_LAST = (TMO_CYC > 1) ? TMO_CYC - 1 : 0;
    logic err_q;
    logic err_d;
`endif

    // Next-state, counter and capture strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
`ifdef MAX_CTRL_TMO_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = (win_len == '0) ? CNT_W'(1) : CNT_W'(win_len);
`ifdef MAX_CTRL_TMO_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (max_done) begin
                    capture = 1'b1;
                    state_d = S_COOL;
                    cnt_d   = CNT_W'(COOL_LOAD);
                end
`ifdef MAX_CTRL_TMO_EN
                else if (cnt_q >= CNT_W'(TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = S_COOL;
                    cnt_d   = CNT_W'(COOL_LOAD);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_COOL: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (res_valid && res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            max_en    <= 1'b0;
            res_valid <= 1'b0;
            res_1     <= '0;
            res_2     <= '0;
            res_3     <= '0;
            res_4     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d != S_IDLE);
            max_en    <= (state_d == S_RUN);
            res_valid <= (state_d == S_HOLD);
            if (capture) begin
                res_1 <= max_out_1;
                res_2 <= max_out_2;
                res_3 <= max_out_3;
                res_4 <= max_out_4;
            end
        end
    end

`ifdef MAX_CTRL_TMO_EN
    // Sticky timeout flag, cleared only when a new window is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_max_ctrl.sv
// Directed bench for max_ctrl: expected captures are queued when max_done is driven and
// checked when res_valid appears. Define MAX_CTRL_TMO_EN to also exercise the timeout.
`timescale 1ns/1ps
module tb_max_ctrl;

    localparam int unsigned COOL_CYC = 4;
    localparam int unsigned TMO_CYC  = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  win_len;
    logic        busy;
    logic        max_en;
    logic        max_done;
    logic [11:0] max_out_1, max_out_2, max_out_3, max_out_4;
    logic [11:0] res_1, res_2, res_3, res_4;
    logic        res_valid;
    logic        res_ready;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [47:0] sb[$];
    logic [47:0] last_res = '0;

    always #5 clk = ~clk;

    max_ctrl #(.COOL_CYC(COOL_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .busy(busy), .max_en(max_en), .max_done(max_done),
        .max_out_1(max_out_1), .max_out_2(max_out_2),
        .max_out_3(max_out_3), .max_out_4(max_out_4),
        .res_1(res_1), .res_2(res_2), .res_3(res_3), .res_4(res_4),
        .res_valid(res_valid), .res_ready(res_ready), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] res_all();
        return {res_4, res_3, res_2, res_1};
    endfunction

    task automatic drive_outs(input logic [47:0] v);
        {max_out_4, max_out_3, max_out_2, max_out_1} = v;
    endtask

    // One complete window; poke drives start (and stray max_done in RUN) where it must be ignored.
    task automatic run_window(input logic [7:0] wl, input logic [47:0] vals, input bit poke,
                              input int hold);
        int exp_len;
        int n;
        exp_len = (wl == 8'd0) ? 1 : int'(wl);
        start   = 1'b1;
        win_len = wl;
        tick();
        start   = 1'b0;
        win_len = 8'hAA;
        check("err_cleared_on_start", 48'(err), 48'd0);
        check("busy_after_start", 48'(busy), 48'd1);
        for (int i = 0; i < exp_len; i++) begin
            check("max_en_in_run", 48'(max_en), 48'd1);
            if (poke) begin
                start    = 1'b1;
                max_done = 1'b1;
                drive_outs({4{12'hFFF}});
            end
            tick();
        end
        start    = 1'b0;
        max_done = 1'b0;
        check("max_en_after_window", 48'(max_en), 48'd0);
        check("busy_in_wait", 48'(busy), 48'd1);
        check("res_unchanged_in_run", res_all(), last_res);
        if (poke) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_ignored_in_wait", 48'(max_en), 48'd0);
        end
        drive_outs(vals);
        max_done = 1'b1;
        sb.push_back(vals);
        tick();
        max_done = 1'b0;
        drive_outs({4{12'h555}});
        last_res = vals;
        check("capture_same_edge", res_all(), vals);
        n = 0;
        while (!res_valid && n < 64) begin
            start = poke;
            tick();
            n++;
        end
        start = 1'b0;
        check("cool_to_valid_cycles", 48'(n), 48'(COOL_CYC));
        for (int k = 0; k < hold; k++) begin
            start     = poke;
            res_ready = 1'b0;
            tick();
            check("valid_held", 48'(res_valid), 48'd1);
            check("res_stable_in_hold", res_all(), vals);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_underflow: observed=result expected=none");
        end else begin
            check("sb_result", res_all(), sb.pop_front());
        end
        res_ready = 1'b1;
        start     = poke;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check("valid_cleared", 48'(res_valid), 48'd0);
        check("busy_idle", 48'(busy), 48'd0);
        check("res_kept_after_hold", res_all(), vals);
        tick();
        check("no_second_window", 48'(busy | max_en), 48'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        win_len   = 8'd0;
        max_done  = 1'b0;
        res_ready = 1'b0;
        drive_outs('0);
        #23;
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_max_en", 48'(max_en), 48'd0);
        check("rst_res_valid", 48'(res_valid), 48'd0);
        check("rst_err", 48'(err), 48'd0);
        check("rst_res", res_all(), 48'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Stray max_done while idle must not capture.
        drive_outs({4{12'h777}});
        max_done = 1'b1;
        tick();
        max_done = 1'b0;
        check("done_ignored_idle", res_all(), 48'd0);

        run_window(8'd3, {4{12'h0A5}}, 1'b0, 0);
        run_window(8'd0, 48'h123_456_789_ABC, 1'b0, 0);
        run_window(8'd4, 48'hFED_CBA_987_654, 1'b1, 2);
        run_window(8'd2, 48'h001_002_003_004, 1'b0, 10);
        run_window(8'd1, 48'hFFF_000_FFF_000, 1'b0, 0);

        // Asynchronous reset in the middle of a window.
        start   = 1'b1;
        win_len = 8'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("max_en_before_rst", 48'(max_en), 48'd1);
        rst_n = 1'b0;
        #1;
        check("rst_drops_max_en", 48'(max_en), 48'd0);
        check("rst_drops_busy", 48'(busy), 48'd0);
        check("rst_clears_res", res_all(), 48'd0);
        last_res = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive_outs({4{12'h3C3}});
            max_done = 1'b1;
            tick();
            check("no_valid_after_rst", 48'(res_valid | busy), 48'd0);
        end
        max_done = 1'b0;
        check("no_capture_after_rst", res_all(), 48'd0);
        run_window(8'd255, 48'h800_400_200_100, 1'b0, 1);

`ifdef MAX_CTRL_TMO_EN
        begin
            int n;
            start   = 1'b1;
            win_len = 8'd2;
            tick();
            start = 1'b0;
            tick();
            tick();
            check("tmo_in_wait", 48'(max_en), 48'd0);
            n = 0;
            while (!err && n < 100) begin
                tick();
                n++;
            end
            check("tmo_wait_cycles", 48'(n), 48'(TMO_CYC));
            check("tmo_no_capture", res_all(), last_res);
            n = 0;
            while (!res_valid && n < 64) begin
                tick();
                n++;
            end
            check("tmo_cool_cycles", 48'(n), 48'(COOL_CYC));
            check("tmo_err_sticky", 48'(err), 48'd1);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("tmo_idle", 48'(busy), 48'd0);
            check("tmo_err_in_idle", 48'(err), 48'd1);
            run_window(8'd2, 48'h0AA_0BB_0CC_0DD, 1'b0, 0);
        end
`else
        check("err_tied_low", 48'(err), 48'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
